// File: rtl/x4xx_done_aggregator.sv
// N-channel completion aggregator: latches sticky per-channel done/fail flags over a run,
// applies an optional watchdog and reports a single pass / fail / timeout verdict.
module x4xx_done_aggregator #(
  parameter  int NUM_CH    = 6,
  parameter  int TIMEOUT_W = 32,
  localparam int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [NUM_CH-1:0]    ch_enable_i,
  input  logic [TIMEOUT_W-1:0] timeout_cycles_i,
  input  logic [NUM_CH-1:0]    done_in_i,
  input  logic [NUM_CH-1:0]    fail_in_i,
  output logic                 busy_o,
  output logic                 all_done_o,
  output logic                 pass_o,
  output logic                 timed_out_o,
  output logic [NUM_CH-1:0]    done_mask_o,
  output logic [NUM_CH-1:0]    fail_mask_o,
  output logic                 first_fail_valid_o,
  output logic [IDX_W-1:0]     first_fail_idx_o,
  output logic [TIMEOUT_W-1:0] elapsed_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [NUM_CH-1:0]      en_q, en_d;
  logic [TIMEOUT_W-1:0]   timeout_q, timeout_d;
  logic [NUM_CH-1:0]      done_mask_q, done_mask_d;
  logic [NUM_CH-1:0]      fail_mask_q, fail_mask_d;
  logic                   ff_valid_q, ff_valid_d;
  logic [IDX_W-1:0]       ff_idx_q, ff_idx_d;
  logic [TIMEOUT_W-1:0]   elapsed_q, elapsed_d;
  logic                   pass_q, pass_d;
  logic                   timed_out_q, timed_out_d;

  logic [NUM_CH-1:0]      fail_now;
  logic [NUM_CH-1:0]      done_new;
  logic [NUM_CH-1:0]      fail_new;
  logic [IDX_W-1:0]       low_idx;
  logic [TIMEOUT_W-1:0]   elapsed_inc;
  logic                   complete;
  logic                   timeout_hit;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d     = state_q;
    en_d        = en_q;
    timeout_d   = timeout_q;
    done_mask_d = done_mask_q;
    fail_mask_d = fail_mask_q;
    ff_valid_d  = ff_valid_q;
    ff_idx_d    = ff_idx_q;
    elapsed_d   = elapsed_q;
    pass_d      = pass_q;
    timed_out_d = timed_out_q;

    fail_now    = fail_in_i & en_q;
    done_new    = done_mask_q | (done_in_i & en_q);
    fail_new    = fail_mask_q | fail_now;
    elapsed_inc = (&elapsed_q) ? elapsed_q : elapsed_q + TIMEOUT_W'(1);

    // Scan downwards so the lowest set bit is the one left standing.
    low_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (fail_now[i]) low_idx = IDX_W'(i);
    end

    // Completion takes priority over a watchdog expiry in the same cycle.
    complete    = ((done_new & en_q) == en_q);
    timeout_hit = (timeout_q != '0) && (elapsed_q == timeout_q - TIMEOUT_W'(1)) && !complete;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d     = S_RUN;
          en_d        = ch_enable_i;
          timeout_d   = timeout_cycles_i;
          done_mask_d = '0;
          fail_mask_d = '0;
          ff_valid_d  = 1'b0;
          ff_idx_d    = '0;
          elapsed_d   = '0;
          pass_d      = 1'b0;
          timed_out_d = 1'b0;
        end
      end
      S_RUN: begin
        done_mask_d = done_new;
        fail_mask_d = fail_new;
        elapsed_d   = elapsed_inc;
        if (!ff_valid_q && (fail_now != '0)) begin
          ff_valid_d = 1'b1;
          ff_idx_d   = low_idx;
        end
        if (complete) begin
          state_d = S_DONE;
          pass_d  = (fail_new == '0);
        end else if (timeout_hit) begin
          state_d     = S_DONE;
          timed_out_d = 1'b1;
          pass_d      = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      en_q        <= '0;
      timeout_q   <= '0;
      done_mask_q <= '0;
      fail_mask_q <= '0;
      ff_valid_q  <= 1'b0;
      ff_idx_q    <= '0;
      elapsed_q   <= '0;
      pass_q      <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      timeout_q   <= timeout_d;
      done_mask_q <= done_mask_d;
      fail_mask_q <= fail_mask_d;
      ff_valid_q  <= ff_valid_d;
      ff_idx_q    <= ff_idx_d;
      elapsed_q   <= elapsed_d;
      pass_q      <= pass_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign busy_o             = (state_q == S_RUN);
  assign all_done_o         = (state_q == S_DONE);
  assign pass_o             = pass_q;
  assign timed_out_o        = timed_out_q;
  assign done_mask_o        = done_mask_q;
  assign fail_mask_o        = fail_mask_q;
  assign first_fail_valid_o = ff_valid_q;
  assign first_fail_idx_o   = ff_idx_q;
  assign elapsed_o          = elapsed_q;

endmodule

// File: tb/tb_x4xx_done_aggregator.sv
// Bench for x4xx_done_aggregator: each run is described by per-channel done/fail cycle numbers
// and the verdict is predicted from those numbers (max/min over enabled channels).
module tb_x4xx_done_aggregator;

  localparam int NUM_CH    = 6;
  localparam int TIMEOUT_W = 32;
  localparam int IDX_W     = 3;
  localparam int NEVER     = 100000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start_i;
  logic [NUM_CH-1:0]    ch_enable_i;
  logic [TIMEOUT_W-1:0] timeout_cycles_i;
  logic [NUM_CH-1:0]    done_in_i;
  logic [NUM_CH-1:0]    fail_in_i;
  logic                 busy_o;
  logic                 all_done_o;
  logic                 pass_o;
  logic                 timed_out_o;
  logic [NUM_CH-1:0]    done_mask_o;
  logic [NUM_CH-1:0]    fail_mask_o;
  logic                 first_fail_valid_o;
  logic [IDX_W-1:0]     first_fail_idx_o;
  logic [TIMEOUT_W-1:0] elapsed_o;

  x4xx_done_aggregator #(.NUM_CH(NUM_CH), .TIMEOUT_W(TIMEOUT_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .start_i            (start_i),
    .ch_enable_i        (ch_enable_i),
    .timeout_cycles_i   (timeout_cycles_i),
    .done_in_i          (done_in_i),
    .fail_in_i          (fail_in_i),
    .busy_o             (busy_o),
    .all_done_o         (all_done_o),
    .pass_o             (pass_o),
    .timed_out_o        (timed_out_o),
    .done_mask_o        (done_mask_o),
    .fail_mask_o        (fail_mask_o),
    .first_fail_valid_o (first_fail_valid_o),
    .first_fail_idx_o   (first_fail_idx_o),
    .elapsed_o          (elapsed_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // RUN-cycle number (1 = first cycle after the accepting edge) on which each channel
  // first raises done / fail.
  int dc [NUM_CH];
  int fc [NUM_CH];

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [NUM_CH-1:0] sticky_mask(input bit use_fail, input logic [NUM_CH-1:0] en,
                                                    input int upto);
    logic [NUM_CH-1:0] m;
    m = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (en[c] && ((use_fail ? fc[c] : dc[c]) <= upto)) m[c] = 1'b1;
    return m;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"},      busy_o,             0);
    check({tag, ".all_done"},  all_done_o,         0);
    check({tag, ".pass"},      pass_o,             0);
    check({tag, ".timed_out"}, timed_out_o,        0);
    check({tag, ".done_mask"}, done_mask_o,        0);
    check({tag, ".fail_mask"}, fail_mask_o,        0);
    check({tag, ".ff_valid"},  first_fail_valid_o, 0);
    check({tag, ".ff_idx"},    first_fail_idx_o,   0);
    check({tag, ".elapsed"},   elapsed_o,          0);
  endtask

  // Called just after a rising edge. Leaves the bench just after a rising edge, DUT in DONE.
  task automatic do_run(input string tag, input logic [NUM_CH-1:0] en, input int to,
                        input bit lvl, input bit noise_const, input bit poke_start);
    int c_cyc, t_cyc, f_cyc, mfc, exp_idx;
    bit exp_to, exp_ffv, exp_pass;
    logic [NUM_CH-1:0] exp_done, exp_fail, dv, fv, frz_done, frz_fail;

    c_cyc = 1;
    for (int c = 0; c < NUM_CH; c++)
      if (en[c] && dc[c] > c_cyc) c_cyc = dc[c];
    t_cyc    = (to == 0) ? NEVER : to;
    exp_to   = (c_cyc > t_cyc);
    f_cyc    = exp_to ? t_cyc : c_cyc;
    exp_done = sticky_mask(1'b0, en, f_cyc);
    exp_fail = sticky_mask(1'b1, en, f_cyc);
    exp_pass = !exp_to && (exp_fail == '0);
    mfc = NEVER;
    for (int c = 0; c < NUM_CH; c++)
      if (en[c] && fc[c] < mfc) mfc = fc[c];
    exp_ffv = (mfc <= f_cyc);
    exp_idx = 0;
    if (exp_ffv)
      for (int c = NUM_CH - 1; c >= 0; c--)
        if (en[c] && fc[c] == mfc) exp_idx = c;

    start_i          = 1'b1;
    ch_enable_i      = en;
    timeout_cycles_i = TIMEOUT_W'(to);
    done_in_i        = NUM_CH'($urandom);
    fail_in_i        = NUM_CH'($urandom);
    @(posedge clk); #1;

    for (int k = 1; k <= f_cyc + 1; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (en[c]) begin
          dv[c] = lvl ? (k >= dc[c]) : (k == dc[c]);
          fv[c] = lvl ? (k >= fc[c]) : (k == fc[c]);
        end else begin
          dv[c] = noise_const ? 1'b1 : 1'($urandom);
          fv[c] = noise_const ? 1'b1 : 1'($urandom);
        end
      end
      done_in_i = dv;
      fail_in_i = fv;
      if (poke_start && k <= f_cyc && $urandom_range(0, 5) == 0) begin
        start_i          = 1'b1;
        ch_enable_i      = NUM_CH'($urandom);
        timeout_cycles_i = TIMEOUT_W'($urandom_range(1, 4));
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      if (k <= f_cyc) begin
        check({tag, ".run_busy"},      busy_o,      1);
        check({tag, ".run_all_done"},  all_done_o,  0);
        check({tag, ".run_pass"},      pass_o,      0);
        check({tag, ".run_timed_out"}, timed_out_o, 0);
        check({tag, ".run_elapsed"},   elapsed_o,   k - 1);
        check({tag, ".run_done_mask"}, done_mask_o, sticky_mask(1'b0, en, k - 1));
        check({tag, ".run_fail_mask"}, fail_mask_o, sticky_mask(1'b1, en, k - 1));
      end else begin
        check({tag, ".busy"},      busy_o,             0);
        check({tag, ".all_done"},  all_done_o,         1);
        check({tag, ".pass"},      pass_o,             exp_pass);
        check({tag, ".timed_out"}, timed_out_o,        exp_to);
        check({tag, ".done_mask"}, done_mask_o,        exp_done);
        check({tag, ".fail_mask"}, fail_mask_o,        exp_fail);
        check({tag, ".ff_valid"},  first_fail_valid_o, exp_ffv);
        check({tag, ".ff_idx"},    first_fail_idx_o,   exp_idx);
        check({tag, ".elapsed"},   elapsed_o,          f_cyc);
      end
      @(posedge clk); #1;
    end

    // Activity on the inputs while in DONE must not move anything.
    frz_done  = done_mask_o;
    frz_fail  = fail_mask_o;
    start_i   = 1'b0;
    done_in_i = '1;
    fail_in_i = '1;
    @(negedge clk);
    check({tag, ".frozen_all_done"},  all_done_o,  1);
    check({tag, ".frozen_done_mask"}, done_mask_o, exp_done);
    check({tag, ".frozen_fail_mask"}, fail_mask_o, exp_fail);
    check({tag, ".frozen_pass"},      pass_o,      exp_pass);
    check({tag, ".frozen_elapsed"},   elapsed_o,   f_cyc);
    n_vec += 0;
    if (frz_done !== exp_done || frz_fail !== exp_fail) begin end
    @(posedge clk); #1;
  endtask

  task automatic clear_fails();
    for (int c = 0; c < NUM_CH; c++) fc[c] = NEVER;
  endtask

  initial begin
    rst              = 1'b1;
    start_i          = 1'b0;
    ch_enable_i      = '0;
    timeout_cycles_i = '0;
    done_in_i        = '0;
    fail_in_i        = '0;
    #2;
    check_all_zero("reset");
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    check_all_zero("idle");

    // Staggered completion, no watchdog.
    dc = '{3, 10, 17, 25, 33, 40};
    clear_fails();
    do_run("stagger", 6'h3F, 0, 1'b0, 1'b0, 1'b0);

    // Two channels fail in the same cycle; lowest index wins.
    dc = '{5, 12, 20, 8, 15, 3};
    clear_fails();
    fc[4] = 10;
    fc[2] = 10;
    do_run("dual_fail", 6'h3F, 0, 1'b0, 1'b0, 1'b0);

    // Watchdog expiry with channel 3 never reporting.
    dc = '{5, 9, 14, NEVER, 2, 2};
    clear_fails();
    do_run("timeout", 6'h0F, 100, 1'b1, 1'b0, 1'b0);

    // Last done on the same cycle the watchdog would fire.
    dc = '{4, 50, 20, 11, 30, 7};
    clear_fails();
    do_run("tie", 6'h3F, 50, 1'b0, 1'b0, 1'b0);

    // Disabled channels held high on both done and fail.
    dc = '{7, NEVER, NEVER, NEVER, NEVER, 12};
    clear_fails();
    do_run("disabled", 6'h21, 0, 1'b1, 1'b1, 1'b0);

    // Empty enable mask finishes immediately with a pass.
    dc = '{NEVER, NEVER, NEVER, NEVER, NEVER, NEVER};
    clear_fails();
    do_run("no_enable", 6'h00, 0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a run.
    start_i          = 1'b1;
    ch_enable_i      = 6'h3F;
    timeout_cycles_i = '0;
    done_in_i        = '0;
    fail_in_i        = '0;
    @(posedge clk); #1;
    start_i   = 1'b0;
    done_in_i = 6'h0B;
    fail_in_i = 6'h02;
    repeat (4) @(posedge clk);
    #3;
    check("pre_rst.busy", busy_o, 1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst       = 1'b0;
    done_in_i = '1;
    fail_in_i = '1;
    @(posedge clk); #1;
    check_all_zero("post_rst");

    // Randomised runs, each started from DONE, with ignored start pokes while busy.
    for (int r = 0; r < 24; r++) begin
      logic [NUM_CH-1:0] en;
      int to;
      en = NUM_CH'($urandom);
      if (r % 8 == 7) en = '0;
      to = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(5, 70);
      for (int c = 0; c < NUM_CH; c++) begin
        dc[c] = $urandom_range(1, 60);
        if (to != 0 && $urandom_range(0, 4) == 0) dc[c] = NEVER;
        fc[c] = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 60) : NEVER;
      end
      do_run($sformatf("rand%0d", r), en, to, 1'($urandom), 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
